// File: rtl/filter_capture_buffer.sv
// filter_capture_buffer
//
// Records DEPTH consecutive filter output samples into an internal RAM and
// replays them, in order, over a valid/ready stream. Sits on the filter's
// output bus and shares its clock and sample enable.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       sample qualifier (same net as the filter enable)
//   inData       filter output sample
//   arm          pulse: start a new capture (accepted in IDLE and FULL)
//   dump         pulse: replay the held record (accepted in FULL)
//   out_data     replayed sample
//   out_valid    out_data is valid
//   out_ready    downstream accepts out_data
//   out_last     out_data is the final sample of the record
//   busy         capture or replay in progress
//   done         a complete record is held
//   sample_count samples written in the current capture
//   stat_min     signed minimum of the record (0 unless stats enabled)
//   stat_max     signed maximum of the record (0 unless stats enabled)
//
// Build option: define FILTER_CAPTURE_STATS_EN to generate min/max tracking.
// Without it, stat_min/stat_max are constant 0.

module filter_capture_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 100,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] inData,
  input  logic              arm,
  input  logic              dump,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_count,
  output logic [DATA_W-1:0] stat_min,
  output logic [DATA_W-1:0] stat_max
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_FULL,
    S_READOUT
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Read stage: registered RAM output plus its valid/last tags. Together
  // with the output register it forms a two-deep pipe, so a sample is
  // already fetched while the previous one waits on out_ready.
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;

  // Output stage
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              we;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              stat_clr;
  logic              adv;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    done_d      = done_q;
    rd_vld_d    = rd_vld_q;
    rd_last_d   = rd_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    we          = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    stat_clr    = 1'b0;
    // Output register may take a new sample when empty or being consumed.
    adv         = !out_valid_q || out_ready;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d  = S_CAPTURE;
          wr_ptr_d = '0;
          cnt_d    = '0;
          done_d   = 1'b0;
          stat_clr = 1'b1;
        end
      end

      S_CAPTURE: begin
        if (enable) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            state_d = S_FULL;
            done_d  = 1'b1;
          end
        end
      end

      S_FULL: begin
        if (arm) begin
          state_d  = S_CAPTURE;
          wr_ptr_d = '0;
          cnt_d    = '0;
          done_d   = 1'b0;
          stat_clr = 1'b1;
        end else if (dump) begin
          // Fetch sample 0 on the same edge that enters READOUT so it
          // reaches the output register one edge later.
          state_d   = S_READOUT;
          rd_en     = 1'b1;
          rd_addr   = '0;
          rd_ptr_d  = CNT_W'(1);
          rd_vld_d  = 1'b1;
          rd_last_d = (LAST_IDX == '0);
        end
      end

      S_READOUT: begin
        if (adv) begin
          out_data_d  = rd_data_q;
          out_valid_d = rd_vld_q;
          out_last_d  = rd_last_q;
        end
        if (!rd_vld_q || adv) begin
          if (rd_ptr_q < DEPTH_C) begin
            rd_en     = 1'b1;
            rd_addr   = rd_ptr_q[AW-1:0];
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_vld_d  = 1'b1;
            rd_last_d = (rd_ptr_q == LAST_IDX);
          end else begin
            rd_vld_d  = 1'b0;
            rd_last_d = 1'b0;
          end
        end
        if (out_valid_q && out_ready && out_last_q) begin
          state_d     = S_FULL;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CAPTURE) || (state_d == S_READOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample RAM: no reset, single write port, registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr_q[AW-1:0]] <= inData;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

`ifdef FILTER_CAPTURE_STATS_EN
  logic signed [DATA_W-1:0] in_s;
  logic signed [DATA_W-1:0] stat_min_q, stat_min_d;
  logic signed [DATA_W-1:0] stat_max_q, stat_max_d;

  assign in_s = inData;

  always_comb begin
    stat_min_d = stat_min_q;
    stat_max_d = stat_max_q;
    if (stat_clr) begin
      stat_min_d = '0;
      stat_max_d = '0;
    end else if (we) begin
      // The first write of a capture seeds both extremes.
      if (cnt_q == '0) begin
        stat_min_d = in_s;
        stat_max_d = in_s;
      end else begin
        if (in_s < stat_min_q) stat_min_d = in_s;
        if (in_s > stat_max_q) stat_max_d = in_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_min_q <= '0;
      stat_max_q <= '0;
    end else begin
      stat_min_q <= stat_min_d;
      stat_max_q <= stat_max_d;
    end
  end

  assign stat_min = stat_min_q;
  assign stat_max = stat_max_q;
`else
  assign stat_min = '0;
  assign stat_max = '0;
`endif

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = cnt_q;

endmodule

// File: doc/filter_capture_buffer.md
Name: filter_capture_buffer

Overview:
- Output-side counterpart of the stimulus memory that feeds `filter`.
- Captures DEPTH consecutive 16-bit filter output samples (`outData`, qualified by `enable`) into an internal RAM.
- Replays the captured samples in order over a valid/ready stream, so a bench or an on-chip host can drain and compare the filtered record.
- Sits directly on `filter`'s output bus, on the same clock.

Parameters:
- DATA_W, 16, sample width; matches the filter `inData`/`outData` width.
- DEPTH, 100, samples per capture; matches the 100-entry stimulus record.
- CNT_W, $clog2(DEPTH+1), width of the sample counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  sample qualifier, same net as the filter enable.
- inData  input  DATA_W  filter `outData`.
- arm  input  1  single-cycle pulse; start a new capture.
- dump  input  1  single-cycle pulse; start replay of the captured record.
- out_data  output  DATA_W  replayed sample.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  marks sample DEPTH-1 of the replay.
- busy  output  1  high in CAPTURE or READOUT.
- done  output  1  record complete and held.
- sample_count  output  CNT_W  samples written in the current capture.
- stat_min  output  DATA_W  signed minimum of the record (optional feature).
- stat_max  output  DATA_W  signed maximum of the record (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all outputs 0; write and read pointers 0.
  - RAM contents are not reset.
  - Reset asserted mid-capture or mid-readout aborts it immediately; after release the block is in IDLE with done=0.
- States: IDLE, CAPTURE, FULL, READOUT.
- IDLE:
  - arm → CAPTURE.
  - dump is ignored.
- CAPTURE:
  - On entry: wr_ptr=0, sample_count=0, done=0.
  - Each cycle with enable=1: mem[wr_ptr] <= inData, wr_ptr++, sample_count++.
  - Cycles with enable=0: no write; pointer and count hold.
  - When the write at wr_ptr==DEPTH-1 occurs: next state FULL, and done=1 on the following cycle. sample_count then reads DEPTH.
  - arm and dump are ignored.
- FULL:
  - done=1; the record is held indefinitely.
  - arm → CAPTURE (re-capture, done drops).
  - dump → READOUT.
  - arm and dump in the same cycle: arm wins.
- READOUT:
  - On entry: rd_ptr=0.
  - out_valid rises 1 cycle after dump is sampled, with out_data=mem[0]. RAM read is registered; dump-to-first-valid latency is 2 clk edges.
  - Transfer occurs on a cycle with out_valid && out_ready; the next sample is presented on the following cycle.
  - Sustained out_ready=1 gives 1 sample per clock with no bubbles. A prefetch register is allowed to achieve this.
  - With out_ready=0, out_data, out_valid and out_last hold stable.
  - out_last=1 only while out_data=mem[DEPTH-1].
  - After the last transfer: out_valid=0 and the next state is FULL. done stays 1, so replay can be repeated.
  - arm and dump are ignored.
- busy = (state==CAPTURE || state==READOUT).
- No wrap-around: exactly DEPTH samples per capture. Further enable pulses in FULL are not written.

Optional Feature:
- Macro: FILTER_CAPTURE_STATS_EN.
- Defined:
  - stat_min and stat_max track the signed min/max of the samples written during CAPTURE.
  - Both are initialised from the first written sample, and update in the same cycle the sample is written.
  - Both are cleared to 0 on arm and on reset; they hold in FULL and READOUT.
- Undefined: stat_min and stat_max are tied to 0 and no tracking logic is generated. The ports remain present.

Test Plan:
- Reset, arm, 100 cycles with enable=1 and inData=0..99 → done=1 after the 100th write; sample_count=100; busy=0 in FULL.
- Same capture with enable toggling 1,0,1,0 → exactly 100 writes after 200 cycles; the gaps add no entries.
- dump with out_ready=1 → out_valid 2 edges after dump; out_data sequence 0..99 on consecutive cycles; out_last only on 99; state returns to FULL.
- dump with out_ready low on every third cycle → no sample lost or duplicated; out_data stable while stalled; second dump replays an identical 0..99.
- rst_n pulsed low at sample 50 of a capture → outputs 0 immediately; dump after release is ignored; a fresh arm captures 100 new samples.
- FILTER_CAPTURE_STATS_EN defined, inputs include 16'h8000 and 16'h7FFF → stat_min=16'h8000, stat_max=16'h7FFF; with the macro undefined, both read 0.
